l2_request_scheduler: RTL
=========================

L2_REQUEST_SCHEDULER -- requirements
Module: l2_request_scheduler

Interface
REQ-001 SHALL have parameter s_line, 256, cache line width in bits.
REQ-002 SHALL have parameter s_addr, 32, address width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port i_read  input  1  icache miss read request; held until i_resp.
REQ-006 SHALL have port i_address  input  s_addr  icache line address.
REQ-007 SHALL have port i_resp / i_rdata  output  1 / s_line  icache completion pulse and line data.
REQ-008 SHALL have port d_read / d_write  input  1 / 1  dcache fill / writeback request; held until d_resp.
REQ-009 SHALL have port d_address / d_wdata  input  s_addr / s_line  dcache line address and writeback data.
REQ-010 SHALL have port d_resp / d_rdata  output  1 / s_line  dcache completion pulse and line data.
REQ-011 SHALL have port l2_read / l2_write / l2_address / l2_wdata  output  1/1/s_addr/s_line  shared L2 command.
REQ-012 SHALL have port l2_resp / l2_rdata  input  1 / s_line  L2 completion and read data.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE: SHALL evaluate requests each cycle; if exactly one side requests, it is granted; if both request, the side not granted last is granted (round-robin pointer `last`).
REQ-015 On grant: SHALL register owner, op, address and wdata into a command register, update `last`, and go to BUSY.
REQ-016 BUSY: SHALL drive l2_read/l2_write/l2_address/l2_wdata solely from the command register; commands asserted from the cycle after grant until and including the cycle l2_resp is sampled high.
REQ-017 On l2_resp in BUSY: SHALL capture l2_rdata into a line buffer and go to RESP; L2 command deasserted the next cycle.
REQ-018 RESP: SHALL assert owner's x_resp for exactly one cycle; the other side's resp stays 0; go to IDLE.
REQ-019 i_rdata and d_rdata SHALL both be driven from the line buffer at all times.
REQ-020 Latency: a request seen in IDLE at cycle 0 SHALL raise the L2 command at cycle 1; l2_resp at cycle k SHALL give x_resp at cycle k+1; the next grant can occur at cycle k+2.
REQ-021 d_read and d_write both high SHALL be treated as a write.
REQ-022 Request inputs deasserted or changed during BUSY/RESP SHALL be ignored; the latched transaction completes.
REQ-023 A continuously requesting side SHALL wait at most one foreign transaction.
REQ-024 i_read/d_read/d_write high in RESP for the owner SHALL NOT re-grant in that cycle.

Reset
REQ-025 With rst_n low at an edge: state=IDLE, last=dcache (icache wins the first tie), command register, line buffer and all outputs 0 from the next cycle.
REQ-026 Reset mid-BUSY SHALL abandon the transaction; a late l2_resp in IDLE SHALL be ignored.

Configuration
REQ-027 Macro L2_SCHED_PERF_EN SHALL, when defined, add input perf_clear (1) and outputs perf_i_grants, perf_d_grants, perf_conflicts (32 each): grants per side, and IDLE cycles with both sides requesting; wrap at 2^32; cleared by reset or perf_clear (clear wins over increment).
REQ-028 Without L2_SCHED_PERF_EN, these ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-029 Package l2_sched_pkg SHALL hold the state enum (IDLE, BUSY, RESP), owner enum (OWN_I, OWN_D) and the op encoding.
REQ-030 Counters SHALL live in sub-module l2_sched_perf, instantiated only under L2_SCHED_PERF_EN.

Verification
REQ-031 i_read=1, addr 0x0000_0100; L2 responds at cycle 4 with data 0xA5..A5 -> l2_read cycles 1-4, i_resp=1 only at cycle 5, i_rdata=0xA5..A5.
REQ-032 i_read and d_read both rise at cycle 0 after reset -> icache granted first, dcache granted at cycle k+2; perf_conflicts=1.
REQ-033 Both sides requesting continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
REQ-034 d_write=1, addr 0x0000_0D80, d_wdata=0x1234..; d_address changed at cycle 2 -> l2_write with l2_address=0x0D80 and the original wdata until l2_resp; d_resp single pulse.
REQ-035 rst_n low in BUSY, l2_resp arrives 2 cycles later -> no i_resp/d_resp, L2 command 0, state IDLE.
REQ-036 d_read=d_write=1 -> l2_write=1, l2_read=0.

Source files
------------

// File: rtl/l2_sched_pkg.sv
// Shared types for the L2 request scheduler: FSM states, owner and op encodings.
package l2_sched_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

    // A dcache request with both strobes set carries dirty data, so it is a write.
    function automatic op_t d_op(input logic wr);
        return wr ? OP_WRITE : OP_READ;
    endfunction

endpackage

// File: rtl/l2_sched_perf.sv
// Grant and conflict counters for the L2 request scheduler (wrap at 2^32, clear beats increment).
module l2_sched_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        inc_i,
    input  logic        inc_d,
    input  logic        inc_conflict,
    output logic [31:0] i_grants,
    output logic [31:0] d_grants,
    output logic [31:0] conflicts
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            i_grants  <= '0;
            d_grants  <= '0;
            conflicts <= '0;
        end else begin
            if (inc_i)        i_grants  <= i_grants + 32'd1;
            if (inc_d)        d_grants  <= d_grants + 32'd1;
            if (inc_conflict) conflicts <= conflicts + 32'd1;
        end
    end

endmodule

// File: rtl/l2_request_scheduler.sv
// Round-robin arbiter sharing one L2 port between icache and dcache misses.
// Optional counters are enabled with the L2_SCHED_PERF_EN macro.
module l2_request_scheduler
    import l2_sched_pkg::*;
#(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [s_addr-1:0] i_address,
    output logic              i_resp,
    output logic [s_line-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic              d_resp,
    output logic [s_line-1:0] d_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [s_addr-1:0] l2_address,
    output logic [s_line-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [s_line-1:0] l2_rdata
`ifdef L2_SCHED_PERF_EN
    ,
    input  logic              perf_clear,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
`endif
);

    state_t            state, state_nxt;
    owner_t            last, cmd_owner;
    op_t               cmd_op;
    logic [s_addr-1:0] cmd_addr;
    logic [s_line-1:0] cmd_wdata, line_buf;
    logic              i_req, d_req, grant_i, grant_d;

    always_comb begin
        i_req   = i_read;
        d_req   = d_read | d_write;
        grant_i = (state == IDLE) && i_req && (!d_req || last == OWN_D);
        grant_d = (state == IDLE) && d_req && !grant_i;
    end

    always_comb begin
        state_nxt  = state;
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = '0;
        l2_wdata   = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            IDLE: if (grant_i || grant_d) state_nxt = BUSY;
            BUSY: begin
                l2_read    = (cmd_op == OP_READ);
                l2_write   = (cmd_op == OP_WRITE);
                l2_address = cmd_addr;
                l2_wdata   = cmd_wdata;
                if (l2_resp) state_nxt = RESP;
            end
            RESP: begin
                i_resp    = (cmd_owner == OWN_I);
                d_resp    = (cmd_owner == OWN_D);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign i_rdata = line_buf;
    assign d_rdata = line_buf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= OWN_D;
            cmd_owner <= OWN_I;
            cmd_op    <= OP_READ;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            line_buf  <= '0;
        end else begin
            state <= state_nxt;
            if (grant_i || grant_d) begin
                last      <= grant_d ? OWN_D : OWN_I;
                cmd_owner <= grant_d ? OWN_D : OWN_I;
                cmd_op    <= grant_d ? d_op(d_write) : OP_READ;
                cmd_addr  <= grant_d ? d_address : i_address;
                cmd_wdata <= grant_d ? d_wdata : '0;
            end
            if (state == BUSY && l2_resp) line_buf <= l2_rdata;
        end
    end

`ifdef L2_SCHED_PERF_EN
    l2_sched_perf u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (perf_clear),
        .inc_i        (grant_i),
        .inc_d        (grant_d),
        .inc_conflict ((state == IDLE) && i_req && d_req),
        .i_grants     (perf_i_grants),
        .d_grants     (perf_d_grants),
        .conflicts    (perf_conflicts)
    );
`endif

endmodule
